// File: rtl/mmio_fifo_pkg.sv
// Shared register map and bit positions for the MMIO transmit FIFO responder.
package mmio_fifo_pkg;
  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_THRESH = 2'd3
  } reg_e;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_BADW  = 3;
  localparam int ST_CNT   = 8;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_OUTEN = 2;

  localparam logic [3:0] WORD_STRB_FULL = 4'b1111;
endpackage

// File: rtl/mmio_fifo_responder_if.sv
// CPU data-port bus plus outbound stream and interrupt of the MMIO FIFO responder.
interface mmio_fifo_responder_if #(parameter int DATA_W = 32);
  logic              sel_i;
  logic [3:0]        we_i;
  logic [31:0]       addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ready_i;
  logic              irq_o;

  modport slave  (input  sel_i, we_i, addr_i, wdata_i, m_ready_i,
                  output rdata_o, m_valid_o, m_data_o, irq_o);
  modport master (output sel_i, we_i, addr_i, wdata_i, m_ready_i,
                  input  rdata_o, m_valid_o, m_data_o, irq_o);
endinterface

// File: rtl/mmio_fifo_responder_sync_fifo.sv
// Show-ahead synchronous FIFO; callers present only legal push/pop requests.
module sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      if (push_i && !pop_i) cnt_d = cnt_q + CNT_W'(1);
      if (!push_i && pop_i) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= din_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/mmio_fifo_responder.sv
// CPU-side transmit FIFO behind the data-memory port; register decode, sticky status, irq.
// Define MMIO_FIFO_WATERMARK_EN to build the THRESH register and low-water irq_o.
module mmio_fifo_responder
  import mmio_fifo_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mmio_fifo_responder_if.slave  bus
);
  reg_e              rsel;
  logic              wr, ctrl_wr, push_req, push, pop, flush, clr, ovf_set, bw_set;
  logic              full, empty;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic              out_en_q, out_en_d, ovf_q, ovf_d, bw_q, bw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              unused_addr;

  assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};
  assign rsel     = reg_e'(bus.addr_i[3:2]);
  assign wr       = bus.sel_i && (bus.we_i != 4'b0000);
  assign push_req = wr && (rsel == REG_TXDATA) && (bus.we_i == WORD_STRB_FULL);
  assign bw_set   = wr && (rsel == REG_TXDATA) && (bus.we_i != WORD_STRB_FULL);
  assign ctrl_wr  = wr && (rsel == REG_CTRL) && bus.we_i[0];
  assign flush    = ctrl_wr && bus.wdata_i[CTRL_FLUSH];
  assign clr      = ctrl_wr && bus.wdata_i[CTRL_CLR];
  assign out_en_d = ctrl_wr ? bus.wdata_i[CTRL_OUTEN] : out_en_q;

  assign bus.m_valid_o = out_en_q && !empty;
  assign bus.m_data_o  = head;

  // A flush swallows same-cycle traffic; a pop frees the slot a full-FIFO push needs.
  assign pop     = bus.m_valid_o && bus.m_ready_i && !flush;
  assign push    = push_req && (!full || pop) && !flush;
  assign ovf_set = push_req && full && !pop && !flush;
  assign ovf_d   = (ovf_q && !clr) || ovf_set;
  assign bw_d    = (bw_q && !clr) || bw_set;

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk(clk), .reset(reset),
    .push_i(push), .pop_i(pop), .flush_i(flush), .din_i(bus.wdata_i),
    .head_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );

`ifdef MMIO_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             irq_q;

  always_comb begin
    thresh_d = thresh_q;
    if (wr && (rsel == REG_THRESH))
      for (int b = 0; b < CNT_W; b++)
        if (bus.we_i[b/8]) thresh_d[b] = bus.wdata_i[b];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= (count < thresh_q) && out_en_q;
    end
  end
  assign bus.irq_o = irq_q;
`else
  assign bus.irq_o = 1'b0;
`endif

  // Read data reflects state before this cycle's writes.
  always_comb begin
    rdata_d = '0;
    if (bus.sel_i) begin
      case (rsel)
        REG_STATUS: begin
          rdata_d[ST_EMPTY]         = empty;
          rdata_d[ST_FULL]          = full;
          rdata_d[ST_OVF]           = ovf_q;
          rdata_d[ST_BADW]          = bw_q;
          rdata_d[ST_CNT +: CNT_W]  = count;
        end
        REG_CTRL: rdata_d[CTRL_OUTEN] = out_en_q;
`ifdef MMIO_FIFO_WATERMARK_EN
        REG_THRESH: rdata_d[CNT_W-1:0] = thresh_q;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      bw_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      out_en_q <= out_en_d;
      ovf_q    <= ovf_d;
      bw_q     <= bw_d;
      rdata_q  <= rdata_d;
    end
  end
  assign bus.rdata_o = rdata_q;
endmodule
